vfp_config_axi_slave: RTL and testbench
=======================================

Name: vfp_config_axi_slave

Overview:
- AXI4-Lite responder holding the VFP configuration register file that the bench-side initiator writes and reads.
- Decodes byte addresses on a 32-bit word grid, latches configuration fields and drives them as static outputs into the filter/video datapath.
- Exposes a read-only revision word and a self-clearing CPU acknowledge pulse.
- Sits between the PS/bench AXI4-Lite master and the VFP core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8, byte address width; word index is addr[7:2].
- REVISION, 32'h09072019, value returned at 0xFC.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  8/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  8/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
- oRgbOsharp, oEdgeType, aBusSelect, threshold, videoChannel, dChannel, cChannel  out  32 each  registers at 0x00, 0x04, 0x0C, 0x10, 0x14, 0x18, 0x1C.
- pointInterest, deltaConfig, cpuWgridLock, cpuAckoffFrame, fifoReadAddress, clearFifoData  out  32 each  registers at 0x7C, 0x80, 0x88, 0x8C, 0x90, 0x94.
- cpuAckGoAgain  out  1  one-cycle pulse on a write to 0x84 with WDATA[0]=1.
- rgbCoord  out  48  {bh,bl,gh,gl,rh,rl}, each byte from WDATA[7:0] at 0xDC..0xC8.
- oLumTh, oHsvPerCh, oYccPerCh  out  32 each  registers at 0xE0, 0xE4, 0xE8.

Behaviour:
- Reset (ARESETN low, asynchronous; released synchronously by the fabric):
  - All READY/VALID outputs are 0; BRESP and RRESP are 0; RDATA is 0; cpuAckGoAgain is 0.
  - All config registers are 0, except rl/gl/bl = 0x00 and rh/gh/bh = 0xFF.
- Reset mid-transaction aborts it silently; no partial register update survives.
- Write path, AW and W independent:
  - AWREADY pulses one cycle when AWVALID is high and no address is held; the address is latched.
  - WREADY works the same way for W, latching data and strobe.
  - The commit happens in the cycle after both are held. Byte lanes are gated by WSTRB.
  - BVALID rises with the commit and holds until BREADY; BRESP is always OKAY (00).
  - No new AW/W is accepted while BVALID=1.
  - If AW and W arrive in the same cycle: both are accepted, commit is next cycle, BVALID follows in that same commit cycle (write latency 2 clocks from valid to BVALID).
- Unmapped or read-only addresses (0x08, 0x20-0x78, 0x98-0xC4, 0xEC-0xFC): the write is ignored but still completes with OKAY.
- cpuAckGoAgain:
  - High for exactly one cycle, in the commit cycle of a write to 0x84 with WDATA[0]=1.
  - Readback of 0x84 is always 0.
- Read path:
  - ARREADY pulses one cycle when ARVALID=1 and RVALID=0.
  - RDATA is registered from the decode on the next edge, and RVALID rises together with it.
  - RVALID and RDATA hold until RREADY; RRESP is OKAY. Read latency is 1 clock after acceptance.
  - Unmapped reads return 0. 0xFC returns REVISION. rgbCoord fields read back zero-extended in bits [7:0].
- Simultaneous events:
  - A read accepted in the same cycle as a write commit to the same address returns the pre-write value.
  - Reads and writes proceed concurrently otherwise.
- Back-pressure: with BREADY or RREADY held low indefinitely, the responder stalls only that channel. The other channel keeps operating.
- Address bits [1:0] are ignored.

Test Plan:
- Reset: pulse ARESETN low mid-write → all outputs 0, rgbCoord=48'hFF00FF00FF00, read 0x84 → 0, and the aborted write leaves threshold=0.
- Write 0x10 ← 20 with AW/W same cycle, BREADY=1 → BVALID exactly 2 clocks after valid, BRESP=00, threshold=20, read 0x10 returns 0x00000014.
- AW 3 cycles before W to 0xE0 ← 36, then WSTRB=4'b0010 write 0xE0 ← 0x0000AB00 → oLumTh=0x0000AB24.
- Write 0x84 ← 1 → cpuAckGoAgain high for exactly 1 clock; write 0x84 ← 0 → no pulse.
- Read 0xFC → 0x09072019. Read 0x40 → 0. Write 0xFC ← 0xFFFFFFFF, then read → still 0x09072019 with BRESP=00.
- Hold RREADY=0 for 10 cycles on a read of 0xC8 while writing 0xCC ← 0x80 → RDATA stable at 0x00; write completes, rgbCoord[15:8]=0x80, and the next read of 0xCC returns 0x80.

Source files
------------

// File: rtl/vfp_config_axi_slave_if.sv
// AXI4-Lite bus bundle between the bench/PS initiator and the VFP configuration responder.
interface vfp_config_axi_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/vfp_config_axi_slave.sv
// AXI4-Lite responder holding the VFP configuration register file; fields drive the
// filter/video datapath as static outputs, plus a revision word and a CPU ack pulse.
module vfp_config_axi_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [31:0] REVISION           = 32'h09072019
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  vfp_config_axi_slave_if.slave s_axi,
  output logic [31:0]           oRgbOsharp,
  output logic [31:0]           oEdgeType,
  output logic [31:0]           aBusSelect,
  output logic [31:0]           threshold,
  output logic [31:0]           videoChannel,
  output logic [31:0]           dChannel,
  output logic [31:0]           cChannel,
  output logic [31:0]           pointInterest,
  output logic [31:0]           deltaConfig,
  output logic [31:0]           cpuWgridLock,
  output logic [31:0]           cpuAckoffFrame,
  output logic [31:0]           fifoReadAddress,
  output logic [31:0]           clearFifoData,
  output logic                  cpuAckGoAgain,
  output logic [47:0]           rgbCoord,
  output logic [31:0]           oLumTh,
  output logic [31:0]           oHsvPerCh,
  output logic [31:0]           oYccPerCh
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [31:0] rgbOsharp, edgeType, busSelect, threshold, videoChannel, dChannel, cChannel;
    logic [31:0] pointInterest, deltaConfig, wgridLock, ackoffFrame, fifoReadAddress, clearFifoData;
    logic [31:0] lumTh, hsvPerCh, yccPerCh;
    logic [7:0]  bh, bl, gh, gl, rh, rl;
  } cfg_t;

  localparam cfg_t CfgReset = '{bh: 8'hFF, gh: 8'hFF, rh: 8'hFF, default: '0};

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldV,
                                                input logic [DW-1:0] newV,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = oldV;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[i*8 +: 8] = newV[i*8 +: 8];
    end
    return res;
  endfunction

  logic          awReady_q, awReady_d, awHeld_q, awHeld_d;
  logic [AW-1:0] awAddr_q, awAddr_d;
  logic          wReady_q, wReady_d, wHeld_q, wHeld_d;
  logic [DW-1:0] wData_q, wData_d;
  logic [SW-1:0] wStrb_q, wStrb_d;
  logic          bValid_q, bValid_d;
  logic          ackPulse_q, ackPulse_d;
  cfg_t          cfg_q, cfg_d;
  logic          arReady_q, arReady_d, rValid_q, rValid_d;
  logic [DW-1:0] rData_q, rData_d;
  logic          commit;
  logic [AW-1:0] arAddr;
  logic [DW-1:0] readWord;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awReady_q  <= 1'b0;
      awHeld_q   <= 1'b0;
      awAddr_q   <= '0;
      wReady_q   <= 1'b0;
      wHeld_q    <= 1'b0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      bValid_q   <= 1'b0;
      ackPulse_q <= 1'b0;
      cfg_q      <= CfgReset;
      arReady_q  <= 1'b0;
      rValid_q   <= 1'b0;
      rData_q    <= '0;
    end else begin
      awReady_q  <= awReady_d;
      awHeld_q   <= awHeld_d;
      awAddr_q   <= awAddr_d;
      wReady_q   <= wReady_d;
      wHeld_q    <= wHeld_d;
      wData_q    <= wData_d;
      wStrb_q    <= wStrb_d;
      bValid_q   <= bValid_d;
      ackPulse_q <= ackPulse_d;
      cfg_q      <= cfg_d;
      arReady_q  <= arReady_d;
      rValid_q   <= rValid_d;
      rData_q    <= rData_d;
    end
  end

  // AW and W are captured independently; the register update lands one edge after both are held.
  always_comb begin
    awReady_d  = 1'b0;
    awHeld_d   = awHeld_q;
    awAddr_d   = awAddr_q;
    wReady_d   = 1'b0;
    wHeld_d    = wHeld_q;
    wData_d    = wData_q;
    wStrb_d    = wStrb_q;
    bValid_d   = bValid_q;
    ackPulse_d = 1'b0;
    cfg_d      = cfg_q;
    commit     = awHeld_q && wHeld_q;

    if (s_axi.S_AXI_AWVALID && !awHeld_q && !bValid_q) begin
      awReady_d = 1'b1;
      awHeld_d  = 1'b1;
      awAddr_d  = {s_axi.S_AXI_AWADDR[AW-1:2], 2'b00};
    end
    if (s_axi.S_AXI_WVALID && !wHeld_q && !bValid_q) begin
      wReady_d = 1'b1;
      wHeld_d  = 1'b1;
      wData_d  = s_axi.S_AXI_WDATA;
      wStrb_d  = s_axi.S_AXI_WSTRB;
    end

    if (commit) begin
      awHeld_d   = 1'b0;
      wHeld_d    = 1'b0;
      bValid_d   = 1'b1;
      ackPulse_d = (awAddr_q == 8'h84) && wData_q[0];
      case (awAddr_q)
        8'h00: cfg_d.rgbOsharp       = mergeBytes(cfg_q.rgbOsharp, wData_q, wStrb_q);
        8'h04: cfg_d.edgeType        = mergeBytes(cfg_q.edgeType, wData_q, wStrb_q);
        8'h0C: cfg_d.busSelect       = mergeBytes(cfg_q.busSelect, wData_q, wStrb_q);
        8'h10: cfg_d.threshold       = mergeBytes(cfg_q.threshold, wData_q, wStrb_q);
        8'h14: cfg_d.videoChannel    = mergeBytes(cfg_q.videoChannel, wData_q, wStrb_q);
        8'h18: cfg_d.dChannel        = mergeBytes(cfg_q.dChannel, wData_q, wStrb_q);
        8'h1C: cfg_d.cChannel        = mergeBytes(cfg_q.cChannel, wData_q, wStrb_q);
        8'h7C: cfg_d.pointInterest   = mergeBytes(cfg_q.pointInterest, wData_q, wStrb_q);
        8'h80: cfg_d.deltaConfig     = mergeBytes(cfg_q.deltaConfig, wData_q, wStrb_q);
        8'h88: cfg_d.wgridLock       = mergeBytes(cfg_q.wgridLock, wData_q, wStrb_q);
        8'h8C: cfg_d.ackoffFrame     = mergeBytes(cfg_q.ackoffFrame, wData_q, wStrb_q);
        8'h90: cfg_d.fifoReadAddress = mergeBytes(cfg_q.fifoReadAddress, wData_q, wStrb_q);
        8'h94: cfg_d.clearFifoData   = mergeBytes(cfg_q.clearFifoData, wData_q, wStrb_q);
        8'hC8: if (wStrb_q[0]) cfg_d.rl = wData_q[7:0];
        8'hCC: if (wStrb_q[0]) cfg_d.rh = wData_q[7:0];
        8'hD0: if (wStrb_q[0]) cfg_d.gl = wData_q[7:0];
        8'hD4: if (wStrb_q[0]) cfg_d.gh = wData_q[7:0];
        8'hD8: if (wStrb_q[0]) cfg_d.bl = wData_q[7:0];
        8'hDC: if (wStrb_q[0]) cfg_d.bh = wData_q[7:0];
        8'hE0: cfg_d.lumTh           = mergeBytes(cfg_q.lumTh, wData_q, wStrb_q);
        8'hE4: cfg_d.hsvPerCh        = mergeBytes(cfg_q.hsvPerCh, wData_q, wStrb_q);
        8'hE8: cfg_d.yccPerCh        = mergeBytes(cfg_q.yccPerCh, wData_q, wStrb_q);
        default: ;
      endcase
    end else if (bValid_q && s_axi.S_AXI_BREADY) begin
      bValid_d = 1'b0;
    end
  end

  // Read decode sees the pre-commit register values, so a colliding write is not visible yet.
  always_comb begin
    arAddr   = {s_axi.S_AXI_ARADDR[AW-1:2], 2'b00};
    readWord = '0;
    case (arAddr)
      8'h00: readWord = cfg_q.rgbOsharp;
      8'h04: readWord = cfg_q.edgeType;
      8'h0C: readWord = cfg_q.busSelect;
      8'h10: readWord = cfg_q.threshold;
      8'h14: readWord = cfg_q.videoChannel;
      8'h18: readWord = cfg_q.dChannel;
      8'h1C: readWord = cfg_q.cChannel;
      8'h7C: readWord = cfg_q.pointInterest;
      8'h80: readWord = cfg_q.deltaConfig;
      8'h88: readWord = cfg_q.wgridLock;
      8'h8C: readWord = cfg_q.ackoffFrame;
      8'h90: readWord = cfg_q.fifoReadAddress;
      8'h94: readWord = cfg_q.clearFifoData;
      8'hC8: readWord = {24'h0, cfg_q.rl};
      8'hCC: readWord = {24'h0, cfg_q.rh};
      8'hD0: readWord = {24'h0, cfg_q.gl};
      8'hD4: readWord = {24'h0, cfg_q.gh};
      8'hD8: readWord = {24'h0, cfg_q.bl};
      8'hDC: readWord = {24'h0, cfg_q.bh};
      8'hE0: readWord = cfg_q.lumTh;
      8'hE4: readWord = cfg_q.hsvPerCh;
      8'hE8: readWord = cfg_q.yccPerCh;
      8'hFC: readWord = REVISION;
      default: readWord = '0;
    endcase
  end

  always_comb begin
    arReady_d = s_axi.S_AXI_ARVALID && !arReady_q && !rValid_q;
    rValid_d  = rValid_q;
    rData_d   = rData_q;
    if (arReady_q && s_axi.S_AXI_ARVALID) begin
      rValid_d = 1'b1;
      rData_d  = readWord;
    end else if (rValid_q && s_axi.S_AXI_RREADY) begin
      rValid_d = 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = awReady_q;
  assign s_axi.S_AXI_WREADY  = wReady_q;
  assign s_axi.S_AXI_BVALID  = bValid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arReady_q;
  assign s_axi.S_AXI_RVALID  = rValid_q;
  assign s_axi.S_AXI_RDATA   = rData_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign oRgbOsharp      = cfg_q.rgbOsharp;
  assign oEdgeType       = cfg_q.edgeType;
  assign aBusSelect      = cfg_q.busSelect;
  assign threshold       = cfg_q.threshold;
  assign videoChannel    = cfg_q.videoChannel;
  assign dChannel        = cfg_q.dChannel;
  assign cChannel        = cfg_q.cChannel;
  assign pointInterest   = cfg_q.pointInterest;
  assign deltaConfig     = cfg_q.deltaConfig;
  assign cpuWgridLock    = cfg_q.wgridLock;
  assign cpuAckoffFrame  = cfg_q.ackoffFrame;
  assign fifoReadAddress = cfg_q.fifoReadAddress;
  assign clearFifoData   = cfg_q.clearFifoData;
  assign cpuAckGoAgain   = ackPulse_q;
  assign rgbCoord        = {cfg_q.bh, cfg_q.bl, cfg_q.gh, cfg_q.gl, cfg_q.rh, cfg_q.rl};
  assign oLumTh          = cfg_q.lumTh;
  assign oHsvPerCh       = cfg_q.hsvPerCh;
  assign oYccPerCh       = cfg_q.yccPerCh;
endmodule

// File: tb/tb_vfp_config_axi_slave.sv
// Randomised AXI4-Lite bench for vfp_config_axi_slave with a word-array model of the register map.
module tb_vfp_config_axi_slave;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  vfp_config_axi_slave_if axi ();

  logic [31:0] oRgbOsharp, oEdgeType, aBusSelect, threshold, videoChannel, dChannel, cChannel;
  logic [31:0] pointInterest, deltaConfig, cpuWgridLock, cpuAckoffFrame, fifoReadAddress, clearFifoData;
  logic [31:0] oLumTh, oHsvPerCh, oYccPerCh;
  logic        cpuAckGoAgain;
  logic [47:0] rgbCoord;

  vfp_config_axi_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstN), .s_axi(axi),
    .oRgbOsharp(oRgbOsharp), .oEdgeType(oEdgeType), .aBusSelect(aBusSelect),
    .threshold(threshold), .videoChannel(videoChannel), .dChannel(dChannel),
    .cChannel(cChannel), .pointInterest(pointInterest), .deltaConfig(deltaConfig),
    .cpuWgridLock(cpuWgridLock), .cpuAckoffFrame(cpuAckoffFrame),
    .fifoReadAddress(fifoReadAddress), .clearFifoData(clearFifoData),
    .cpuAckGoAgain(cpuAckGoAgain), .rgbCoord(rgbCoord), .oLumTh(oLumTh),
    .oHsvPerCh(oHsvPerCh), .oYccPerCh(oYccPerCh)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mem [64];
  bit          ackExpected = 1'b0;
  int          ackCount = 0;
  bit          compareOn = 1'b0;

  // Model: one 32-bit word per word index; rgb bytes live in the low byte of their word.
  function automatic bit isWritable(input int idx);
    return (idx inside {0, 1, 3, 4, 5, 6, 7, 31, 32, 34, 35, 36, 37, [50:58]});
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    if (idx == 63) return 32'h09072019;
    if (isWritable(idx)) return mem[idx];
    return 32'h0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[51] = 32'hFF;
    mem[53] = 32'hFF;
    mem[55] = 32'hFF;
  endtask

  task automatic modelWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[7:2]);
    if (idx == 33 && data[0]) ackExpected = 1'b1;
    if (!isWritable(idx)) return;
    if (idx >= 50 && idx <= 55) begin
      if (strb[0]) mem[idx] = {24'h0, data[7:0]};
    end else begin
      for (int b = 0; b < 4; b++) if (strb[b]) mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: every static output must equal what the model says the register map holds.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (compareOn) begin
        checkOutput("oRgbOsharp", oRgbOsharp, mem[0]);
        checkOutput("oEdgeType", oEdgeType, mem[1]);
        checkOutput("aBusSelect", aBusSelect, mem[3]);
        checkOutput("threshold", threshold, mem[4]);
        checkOutput("videoChannel", videoChannel, mem[5]);
        checkOutput("dChannel", dChannel, mem[6]);
        checkOutput("cChannel", cChannel, mem[7]);
        checkOutput("pointInterest", pointInterest, mem[31]);
        checkOutput("deltaConfig", deltaConfig, mem[32]);
        checkOutput("cpuWgridLock", cpuWgridLock, mem[34]);
        checkOutput("cpuAckoffFrame", cpuAckoffFrame, mem[35]);
        checkOutput("fifoReadAddress", fifoReadAddress, mem[36]);
        checkOutput("clearFifoData", clearFifoData, mem[37]);
        checkOutput("rgbCoord", rgbCoord, {mem[55][7:0], mem[54][7:0], mem[53][7:0],
                                           mem[52][7:0], mem[51][7:0], mem[50][7:0]});
        checkOutput("oLumTh", oLumTh, mem[56]);
        checkOutput("oHsvPerCh", oHsvPerCh, mem[57]);
        checkOutput("oYccPerCh", oYccPerCh, mem[58]);
        checkOutput("cpuAckGoAgain", cpuAckGoAgain, ackExpected);
        if (cpuAckGoAgain) ackCount++;
        ackExpected = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge; latency counts negedges from valid until BVALID is seen.
  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, input int bHold, output int latency);
    int lat;
    lat = -1;
    if (bHold > 0) axi.S_AXI_BREADY = 1'b0;
    fork
      begin
        bit got;
        got = 1'b0;
        repeat (awDelay) @(negedge clk);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (axi.S_AXI_AWREADY) begin got = 1'b1; break; end
        end
        if (!got) checkOutput("awreadyTimeout", 0, 1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
      end
      begin
        bit got;
        got = 1'b0;
        repeat (wDelay) @(negedge clk);
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WSTRB  = strb;
        axi.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (axi.S_AXI_WREADY) begin got = 1'b1; break; end
        end
        if (!got) checkOutput("wreadyTimeout", 0, 1);
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
      end
      begin
        for (int c = 1; c <= 200; c++) begin
          @(negedge clk);
          if (axi.S_AXI_BVALID) begin lat = c; break; end
        end
        if (lat < 0) begin
          checkOutput("bvalidTimeout", 0, 1);
        end else begin
          modelWrite(addr, data, strb);
          checkOutput("BRESP", axi.S_AXI_BRESP, 2'b00);
          repeat (bHold) begin
            @(negedge clk);
            checkOutput("bvalidHold", axi.S_AXI_BVALID, 1);
          end
          axi.S_AXI_BREADY = 1'b1;
          @(negedge clk);
          checkOutput("bvalidClear", axi.S_AXI_BVALID, 0);
        end
      end
    join
    axi.S_AXI_BREADY = 1'b1;
    latency = lat;
  endtask

  task automatic readReg(input logic [7:0] addr, input int rHold, output logic [31:0] data);
    bit got;
    logic [31:0] expected;
    got  = 1'b0;
    data = 32'h0;
    if (rHold > 0) axi.S_AXI_RREADY = 1'b0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axi.S_AXI_ARREADY) begin got = 1'b1; break; end
    end
    if (!got) begin
      checkOutput("arreadyTimeout", 0, 1);
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY  = 1'b1;
      return;
    end
    #1 expected = modelRead(addr);
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    checkOutput("rvalidLatency", axi.S_AXI_RVALID, 1);
    checkOutput("rdata", axi.S_AXI_RDATA, expected);
    checkOutput("RRESP", axi.S_AXI_RRESP, 2'b00);
    data = axi.S_AXI_RDATA;
    repeat (rHold) begin
      @(negedge clk);
      checkOutput("rvalidHold", axi.S_AXI_RVALID, 1);
      checkOutput("rdataHold", axi.S_AXI_RDATA, expected);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    checkOutput("rvalidClear", axi.S_AXI_RVALID, 0);
  endtask

  task automatic checkResetState();
    checkOutput("rstAWREADY", axi.S_AXI_AWREADY, 0);
    checkOutput("rstWREADY", axi.S_AXI_WREADY, 0);
    checkOutput("rstBVALID", axi.S_AXI_BVALID, 0);
    checkOutput("rstARREADY", axi.S_AXI_ARREADY, 0);
    checkOutput("rstRVALID", axi.S_AXI_RVALID, 0);
    checkOutput("rstResp", {axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 4'h0);
    checkOutput("rstRDATA", axi.S_AXI_RDATA, 32'h0);
    checkOutput("rstAck", cpuAckGoAgain, 0);
    checkOutput("rstThreshold", threshold, 32'h0);
    checkOutput("rstLumTh", oLumTh, 32'h0);
    checkOutput("rstRgbCoord", rgbCoord, 48'hFF00FF00FF00);
  endtask

  // Random traffic: concurrent write and read, mixed mapped/unmapped addresses and stalls.
  task automatic applyStimulus(input int iterations);
    logic [7:0]  wAddr, rAddr;
    logic [5:0]  idx;
    logic [1:0]  low;
    logic [31:0] data, rd;
    logic [3:0]  strb;
    int          lat, awD, wD, bH, rH;
    logic [7:0]  mapped [22] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h7C,
                                 8'h80, 8'h88, 8'h8C, 8'h90, 8'h94, 8'hC8, 8'hCC, 8'hD0,
                                 8'hD4, 8'hD8, 8'hDC, 8'hE0, 8'hE4, 8'hE8};
    for (int n = 0; n < iterations; n++) begin
      idx = 6'($urandom_range(0, 63));
      low = 2'($urandom_range(0, 3));
      wAddr = ($urandom_range(0, 1) == 1) ? (mapped[$urandom_range(0, 21)] | {6'h0, low}) : {idx, low};
      idx = 6'($urandom_range(0, 63));
      rAddr = ($urandom_range(0, 1) == 1) ? mapped[$urandom_range(0, 21)] : {idx, 2'b00};
      if ($urandom_range(0, 3) == 0) rAddr = wAddr;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      awD  = $urandom_range(0, 3);
      wD   = $urandom_range(0, 3);
      bH   = $urandom_range(0, 2);
      rH   = $urandom_range(0, 2);
      fork
        writeReg(wAddr, data, strb, awD, wD, bH, lat);
        readReg(rAddr, rH, rd);
      join
    end
  endtask

  initial begin
    logic [31:0] d, d1;
    int          lat, a0;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b1;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetState();
    rstN = 1'b1;
    @(negedge clk);
    compareOn = 1'b1;

    // Reset lands after both channels are held but before the commit edge.
    axi.S_AXI_AWADDR  = 8'h10;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = 32'd99;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    rstN = 1'b0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    #1 checkResetState();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    readReg(8'h84, 0, d);
    checkOutput("read84AfterReset", d, 32'h0);
    checkOutput("thresholdAfterAbort", threshold, 32'h0);

    writeReg(8'h10, 32'd20, 4'hF, 0, 0, 0, lat);
    checkOutput("writeLatency", lat, 2);
    checkOutput("thresholdLit", threshold, 32'd20);
    readReg(8'h10, 0, d);
    checkOutput("read10Lit", d, 32'h00000014);

    writeReg(8'hE0, 32'd36, 4'hF, 0, 3, 0, lat);
    writeReg(8'hE0, 32'h0000AB00, 4'b0010, 0, 0, 0, lat);
    checkOutput("oLumThLit", oLumTh, 32'h0000AB24);

    a0 = ackCount;
    writeReg(8'h84, 32'h1, 4'hF, 0, 0, 0, lat);
    @(negedge clk);
    #3 checkOutput("ackPulseCount1", ackCount - a0, 1);
    a0 = ackCount;
    writeReg(8'h84, 32'h0, 4'hF, 0, 0, 0, lat);
    @(negedge clk);
    #3 checkOutput("ackPulseCount0", ackCount - a0, 0);
    @(negedge clk);

    readReg(8'hFC, 0, d);
    checkOutput("revisionLit", d, 32'h09072019);
    readReg(8'h40, 0, d);
    checkOutput("unmappedLit", d, 32'h0);
    writeReg(8'hFC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, lat);
    readReg(8'hFC, 0, d);
    checkOutput("revisionAfterWrite", d, 32'h09072019);

    fork
      readReg(8'hC8, 10, d1);
      writeReg(8'hCC, 32'h80, 4'hF, 0, 0, 0, lat);
    join
    checkOutput("readC8Stalled", d1, 32'h0);
    checkOutput("rgbRhLit", rgbCoord[15:8], 8'h80);
    readReg(8'hCC, 0, d);
    checkOutput("readCCLit", d, 32'h80);

    applyStimulus(80);

    for (int i = 0; i < 64; i++) begin
      logic [7:0] a;
      a = 8'(i * 4);
      readReg(a, 0, d);
    end

    compareOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
